// File: rtl/tb_stream_pkg.sv
// Shared types for the stream generator/checker: run-state encoding and generator mode codes.
package tb_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MODE_COUNT = 0;
    localparam int MODE_LFSR  = 1;

endpackage

// File: rtl/tb_exp_fifo.sv
// In-order expectation FIFO; dout is the head word, visible combinationally.
// Push is dropped only when full with no same-cycle pop; flush empties it in one cycle.
module tb_exp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tb_stream_gen_chk.sv
// Stream generator plus in-order scoreboard for pipeline benches; stimulus is registered (1 cycle).
// Emission stalls while expectation FIFO plus the pending push would exceed DEPTH; result side never stalls.
module tb_stream_gen_chk
    import tb_stream_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 8,
    parameter int                    N_WORDS    = 16,
    parameter int                    MODE       = 0,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1),
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8),
    parameter int                    VALID_GAP  = 0,
    parameter int                    TIMEOUT    = 64,
    parameter int                    CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] idata,
    output logic                  icontrol,
    input  logic [DATA_WIDTH-1:0] odata,
    input  logic                  ocontrol,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      sent_cnt,
    output logic [CNT_W-1:0]      recv_cnt,
    output logic                  timeout
);
    localparam int FCW = $clog2(DEPTH) + 1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] gen_q, gen_d;
    logic [DATA_WIDTH-1:0] idata_q, idata_d;
    logic                  icontrol_q, icontrol_d;
    logic [CNT_W-1:0]      gap_q, gap_d;
    logic [CNT_W-1:0]      sent_q, sent_d;
    logic [CNT_W-1:0]      recv_q, recv_d;
    logic [CNT_W-1:0]      err_q, err_d;
    logic [CNT_W-1:0]      wd_q, wd_d;
    logic                  timeout_q, timeout_d;

    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [FCW-1:0]        fifo_count, in_flight;
    logic                  fifo_empty, fifo_full;
    logic                  start_ok, emit, wd_active, wd_fire;
    logic                  fifo_push, fifo_pop, bypass, bad_beat;

    function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [DATA_WIDTH-1:0] x);
        if (MODE == MODE_LFSR) return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
        else                   return x + DATA_WIDTH'(1);
    endfunction

    // The word launched last cycle is not in the FIFO yet but already owns a slot.
    assign in_flight = fifo_count + FCW'(icontrol_q);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign wd_active = busy && (!fifo_empty || icontrol_q) && !ocontrol;
    assign wd_fire   = wd_active && (wd_q == CNT_W'(TIMEOUT - 1));
    assign emit      = (state_q == RUN) && (gap_q == '0) && !fifo_full &&
                       (in_flight < FCW'(DEPTH)) && !wd_fire;

    // A zero-latency DUT returns the word on the same edge it would be pushed.
    assign bypass    = ocontrol && fifo_empty && icontrol_q;
    assign fifo_push = icontrol_q && !bypass;
    assign fifo_pop  = ocontrol && !fifo_empty;
    assign bad_beat  = fifo_pop ? (fifo_dout != odata) :
                       bypass   ? (idata_q != odata)   : ocontrol;

    tb_exp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (start_ok),
        .push_i  (fifo_push),
        .din_i   (idata_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = RUN;
            RUN: begin
                if (wd_fire)                                   state_d = DONE;
                else if (emit && sent_q == CNT_W'(N_WORDS - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (wd_fire)                                         state_d = DONE;
                else if (fifo_empty && recv_q >= CNT_W'(N_WORDS))    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gen_d      = gen_q;
        idata_d    = idata_q;
        icontrol_d = emit;
        gap_d      = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        sent_d     = sent_q;
        recv_d     = recv_q;
        err_d      = err_q;
        wd_d       = wd_q;
        timeout_d  = timeout_q;
        if (start_ok) begin
            gen_d      = SEED;
            icontrol_d = 1'b0;
            gap_d      = '0;
            sent_d     = '0;
            recv_d     = '0;
            err_d      = '0;
            wd_d       = '0;
            timeout_d  = 1'b0;
        end else begin
            if (emit) begin
                idata_d = gen_q;
                gen_d   = gen_next(gen_q);
                gap_d   = CNT_W'(VALID_GAP);
                sent_d  = sent_q + 1'b1;
            end
            if (ocontrol) begin
                recv_d = recv_q + 1'b1;
                if (bad_beat && err_q != '1) err_d = err_q + 1'b1;
            end
            if (wd_active)     wd_d = wd_q + 1'b1;
            else if (ocontrol) wd_d = '0;
            if (wd_fire) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gen_q      <= SEED;
            idata_q    <= '0;
            icontrol_q <= 1'b0;
            gap_q      <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            err_q      <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_q      <= gen_d;
            idata_q    <= idata_d;
            icontrol_q <= icontrol_d;
            gap_q      <= gap_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
        end
    end

    assign idata    = idata_q;
    assign icontrol = icontrol_q;
    assign done     = (state_q == DONE);
    assign pass     = done && (err_q == '0) && !timeout_q;
    assign err_cnt  = err_q;
    assign sent_cnt = sent_q;
    assign recv_cnt = recv_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_tb_stream_gen_chk.sv
// Bench: wire-through, 3-register (optionally corrupting) and silent DUTs around three generator instances.
module tb_tb_stream_gen_chk;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stray;
    logic       corrupt;
    logic       start_a    [3];
    logic [7:0] idata_a    [3];
    logic       icontrol_a [3];
    logic [7:0] odata_a    [3];
    logic       ocontrol_a [3];
    logic       busy_a     [3];
    logic       done_a     [3];
    logic       pass_a     [3];
    logic       timeout_a  [3];
    logic [15:0] err_a     [3];
    logic [15:0] sent_a    [3];
    logic [15:0] recv_a    [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] lfsr_ref [6];

    always #5 clk = ~clk;

    // Wire-through DUT, with an injectable stray result beat.
    assign odata_a[0]    = idata_a[0];
    assign ocontrol_a[0] = icontrol_a[0] | stray;

    // Three-register DUT; optionally flips bit0 of its fifth result word.
    logic [8:0] p1, p2, p3;
    logic [3:0] ocnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0; p2 <= '0; p3 <= '0; ocnt <= '0;
        end else begin
            p1 <= {icontrol_a[1], idata_a[1]};
            p2 <= p1;
            p3 <= p2;
            if (start_a[1])  ocnt <= '0;
            else if (p3[8])  ocnt <= ocnt + 4'd1;
        end
    end
    assign ocontrol_a[1] = p3[8];
    assign odata_a[1]    = p3[7:0] ^ {7'd0, corrupt && p3[8] && (ocnt == 4'd4)};

    // Silent DUT: never returns anything.
    assign ocontrol_a[2] = 1'b0;
    assign odata_a[2]    = 8'h00;

    tb_stream_gen_chk #(.MODE(0), .SEED(8'h01), .DEPTH(8)) u_wire (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .idata(idata_a[0]), .icontrol(icontrol_a[0]),
        .odata(odata_a[0]), .ocontrol(ocontrol_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .err_cnt(err_a[0]), .sent_cnt(sent_a[0]), .recv_cnt(recv_a[0]),
        .timeout(timeout_a[0]));

    tb_stream_gen_chk #(.MODE(1), .SEED(8'h01), .VALID_GAP(1)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .idata(idata_a[1]), .icontrol(icontrol_a[1]),
        .odata(odata_a[1]), .ocontrol(ocontrol_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .err_cnt(err_a[1]), .sent_cnt(sent_a[1]), .recv_cnt(recv_a[1]),
        .timeout(timeout_a[1]));

    tb_stream_gen_chk #(.MODE(0), .SEED(8'h01), .DEPTH(4), .TIMEOUT(64)) u_silent (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .idata(idata_a[2]), .icontrol(icontrol_a[2]),
        .odata(odata_a[2]), .ocontrol(ocontrol_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .pass(pass_a[2]), .err_cnt(err_a[2]), .sent_cnt(sent_a[2]), .recv_cnt(recv_a[2]),
        .timeout(timeout_a[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input bit lfsr, input logic [7:0] x);
        if (lfsr) return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
        else      return x + 8'd1;
    endfunction

    task automatic pulse_start(input int k, input bit lfsr);
        logic [7:0] w;
        exp_q.delete();
        w = 8'h01;
        for (int i = 0; i < 16; i++) begin
            if (lfsr && i < 6) w = lfsr_ref[i];
            exp_q.push_back(w);
            w = model_next(lfsr, w);
        end
        @(negedge clk) start_a[k] = 1'b1;
        @(negedge clk) start_a[k] = 1'b0;
    endtask

    // Called at the negedge just after the start edge; watches emitted words until done.
    task automatic run_stream(input int k, input int gap, input int budget, input int n_expect,
                              output int first_c, output int done_c);
        int cyc = 0;
        int last = -1;
        int nw = 0;
        bit seen_done = 1'b0;
        logic [7:0] e;
        first_c = -1;
        done_c  = -1;
        while (cyc < budget) begin
            if (icontrol_a[k]) begin
                if (exp_q.size() == 0) check("extra_word", 32'(1), 32'(0));
                else begin
                    e = exp_q.pop_front();
                    check("idata", 32'(idata_a[k]), 32'(e));
                end
                if (last >= 0) check("spacing", 32'(cyc - last), 32'(gap + 1));
                else           first_c = cyc;
                last = cyc;
                nw++;
            end
            if (done_a[k]) begin
                seen_done = 1'b1;
                done_c = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_reached", 32'(seen_done), 32'(1));
        check("words_emitted", 32'(nw), 32'(n_expect));
    endtask

    initial begin
        int f, d;
        lfsr_ref = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        rst_n   = 1'b0;
        stray   = 1'b0;
        corrupt = 1'b0;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_idata",    32'(idata_a[0]),    32'(0));
        check("rst_icontrol", 32'(icontrol_a[0]), 32'(0));
        check("rst_busy",     32'(busy_a[0]),     32'(0));
        check("rst_done",     32'(done_a[0]),     32'(0));
        check("rst_pass",     32'(pass_a[0]),     32'(0));
        check("rst_err",      32'(err_a[0]),      32'(0));
        check("rst_sent",     32'(sent_a[0]),     32'(0));
        check("rst_recv",     32'(recv_a[0]),     32'(0));
        check("rst_timeout",  32'(timeout_a[0]),  32'(0));
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Stray result beat while idle is an underflow.
        stray = 1'b1;
        @(negedge clk) stray = 1'b0;
        check("idle_underflow_err", 32'(err_a[0]),  32'(1));
        check("idle_underflow_rcv", 32'(recv_a[0]), 32'(1));
        check("idle_not_done",      32'(done_a[0]), 32'(0));

        // Wire-through counter run; start also clears the underflow.
        pulse_start(0, 1'b0);
        check("start_clr_err",  32'(err_a[0]),  32'(0));
        check("start_clr_recv", 32'(recv_a[0]), 32'(0));
        check("start_busy",     32'(busy_a[0]), 32'(1));
        run_stream(0, 0, 100, 16, f, d);
        check("wire_sent", 32'(sent_a[0]), 32'(16));
        check("wire_recv", 32'(recv_a[0]), 32'(16));
        check("wire_err",  32'(err_a[0]),  32'(0));
        check("wire_pass", 32'(pass_a[0]), 32'(1));
        check("wire_busy", 32'(busy_a[0]), 32'(0));

        // LFSR with one-cycle gaps through a 3-register DUT.
        pulse_start(1, 1'b1);
        run_stream(1, 1, 200, 16, f, d);
        check("lfsr_recv", 32'(recv_a[1]), 32'(16));
        check("lfsr_err",  32'(err_a[1]),  32'(0));
        check("lfsr_pass", 32'(pass_a[1]), 32'(1));

        // Same DUT corrupting its fifth result.
        corrupt = 1'b1;
        pulse_start(1, 1'b1);
        run_stream(1, 1, 200, 16, f, d);
        check("corrupt_err",  32'(err_a[1]),  32'(1));
        check("corrupt_pass", 32'(pass_a[1]), 32'(0));
        check("corrupt_recv", 32'(recv_a[1]), 32'(16));
        corrupt = 1'b0;

        // Silent DUT: FIFO fills, watchdog fires 64 cycles after the first emit.
        pulse_start(2, 1'b0);
        run_stream(2, 0, 200, 4, f, d);
        check("silent_sent",      32'(sent_a[2]),     32'(4));
        check("silent_timeout",   32'(timeout_a[2]),  32'(1));
        check("silent_pass",      32'(pass_a[2]),     32'(0));
        check("silent_latency",   32'(d - f),         32'(64));
        check("silent_icontrol",  32'(icontrol_a[2]), 32'(0));

        // Reset in the middle of a run, then a clean rerun from SEED.
        pulse_start(0, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(busy_a[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_icontrol", 32'(icontrol_a[0]), 32'(0));
        check("midrst_idata",    32'(idata_a[0]),    32'(0));
        check("midrst_sent",     32'(sent_a[0]),     32'(0));
        check("midrst_busy",     32'(busy_a[0]),     32'(0));
        check("midrst_done",     32'(done_a[0]),     32'(0));
        check("midrst_timeout2", 32'(timeout_a[2]),  32'(0));
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        pulse_start(0, 1'b0);
        run_stream(0, 0, 100, 16, f, d);
        check("rerun_sent", 32'(sent_a[0]), 32'(16));
        check("rerun_pass", 32'(pass_a[0]), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

endmodule
